// File: rtl/id_exe_reg_if.sv
// ID/EXE pipeline register bus: ID-side fields, hazard controls and registered EXE-side copies.
// When IDEXE_FWD_EN is defined, the rs/rt source indices for the forwarding unit are carried too.
interface id_exe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              hold;
  logic [3:0]        exe_cmd;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        br_type;
  logic              writeback_en;
  logic [DATA_W-1:0] alu_inp1;
  logic [DATA_W-1:0] alu_inp2;
  logic [DATA_W-1:0] reg2;
  logic [REG_AW-1:0] idexe_dest;
  logic [DATA_W-1:0] PC;
`ifdef IDEXE_FWD_EN
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic [REG_AW-1:0] src1_exe;
  logic [REG_AW-1:0] src2_exe;
`endif
  logic [3:0]        exe_cmd_exe;
  logic              mem_write_exe;
  logic              mem_read_exe;
  logic [1:0]        br_type_exe;
  logic              writeback_en_exe;
  logic [DATA_W-1:0] alu_inp1_exe;
  logic [DATA_W-1:0] alu_inp2_exe;
  logic [DATA_W-1:0] reg2_exe;
  logic [REG_AW-1:0] idexe_dest_exe;
  logic [DATA_W-1:0] PC_exe;
  logic              valid_exe;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output stall, flush, hold, exe_cmd, mem_write, mem_read, br_type, writeback_en,
           alu_inp1, alu_inp2, reg2, idexe_dest, PC,
`ifdef IDEXE_FWD_EN
    output src1, src2,
    input  src1_exe, src2_exe,
`endif
    input  exe_cmd_exe, mem_write_exe, mem_read_exe, br_type_exe, writeback_en_exe,
           alu_inp1_exe, alu_inp2_exe, reg2_exe, idexe_dest_exe, PC_exe,
           valid_exe, bubble_cnt
  );

  modport slave (
    input  stall, flush, hold, exe_cmd, mem_write, mem_read, br_type, writeback_en,
           alu_inp1, alu_inp2, reg2, idexe_dest, PC,
`ifdef IDEXE_FWD_EN
    input  src1, src2,
    output src1_exe, src2_exe,
`endif
    output exe_cmd_exe, mem_write_exe, mem_read_exe, br_type_exe, writeback_en_exe,
           alu_inp1_exe, alu_inp2_exe, reg2_exe, idexe_dest_exe, PC_exe,
           valid_exe, bubble_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with bubble insertion (flush/stall), hold, and a saturating bubble counter.
// Optional IDEXE_FWD_EN macro adds src1/src2 index pass-through for the forwarding unit.
module id_exe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic         clock,
  input  logic         reset,
  id_exe_reg_if.slave  bus
);
  typedef struct packed {
    logic [3:0]        exe_cmd;
    logic              mem_write;
    logic              mem_read;
    logic [1:0]        br_type;
    logic              writeback_en;
    logic [DATA_W-1:0] alu_inp1;
    logic [DATA_W-1:0] alu_inp2;
    logic [DATA_W-1:0] reg2;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] pc;
`ifdef IDEXE_FWD_EN
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
`endif
  } pay_t;

  pay_t             pay_in, pay_d, pay_q;
  logic             vld_d, vld_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             bubble;

  always_comb begin
    pay_in              = '0;
    pay_in.exe_cmd      = bus.exe_cmd;
    pay_in.mem_write    = bus.mem_write;
    pay_in.mem_read     = bus.mem_read;
    pay_in.br_type      = bus.br_type;
    pay_in.writeback_en = bus.writeback_en;
    pay_in.alu_inp1     = bus.alu_inp1;
    pay_in.alu_inp2     = bus.alu_inp2;
    pay_in.reg2         = bus.reg2;
    pay_in.dest         = bus.idexe_dest;
    pay_in.pc           = bus.PC;
`ifdef IDEXE_FWD_EN
    pay_in.src1         = bus.src1;
    pay_in.src2         = bus.src2;
`endif
  end

  // flush beats hold; stall only inserts a bubble when EXE is not holding
  assign bubble = bus.flush | (~bus.hold & bus.stall);

  always_comb begin
    pay_d = pay_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (bubble) begin
      pay_d = '0;
      vld_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (!bus.hold) begin
      pay_d = pay_in;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pay_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pay_q <= pay_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // side-effecting controls are qualified by valid so a bubble can never act
  assign bus.exe_cmd_exe      = pay_q.exe_cmd;
  assign bus.mem_write_exe    = pay_q.mem_write & vld_q;
  assign bus.mem_read_exe     = pay_q.mem_read & vld_q;
  assign bus.br_type_exe      = pay_q.br_type & {2{vld_q}};
  assign bus.writeback_en_exe = pay_q.writeback_en & vld_q;
  assign bus.alu_inp1_exe     = pay_q.alu_inp1;
  assign bus.alu_inp2_exe     = pay_q.alu_inp2;
  assign bus.reg2_exe         = pay_q.reg2;
  assign bus.idexe_dest_exe   = pay_q.dest;
  assign bus.PC_exe           = pay_q.pc;
  assign bus.valid_exe        = vld_q;
  assign bus.bubble_cnt       = cnt_q;
`ifdef IDEXE_FWD_EN
  assign bus.src1_exe         = pay_q.src1;
  assign bus.src2_exe         = pay_q.src2;
`endif
endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: a 16-bit-counter DUT and a 4-bit-counter DUT share stimulus.
module tb_id_exe_reg;
  typedef struct packed {
    logic [3:0]  cmd;
    logic        mw;
    logic        mr;
    logic [1:0]  br;
    logic        wb;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] r2;
    logic [4:0]  dest;
    logic [31:0] pc;
`ifdef IDEXE_FWD_EN
    logic [4:0]  s1;
    logic [4:0]  s2;
`endif
  } pay_t;

  typedef struct packed {
    pay_t        pay;
    logic        v;
    logic [15:0] c;
    logic [3:0]  c4;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic st, fl, ho;
  pay_t drv;
  exp_t mdl;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_exe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) ifa ();
  id_exe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  ifb ();

  id_exe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
  id_exe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut_b (.clock(clk), .reset(rst), .bus(ifb));

  assign ifa.stall = st;           assign ifb.stall = st;
  assign ifa.flush = fl;           assign ifb.flush = fl;
  assign ifa.hold = ho;            assign ifb.hold = ho;
  assign ifa.exe_cmd = drv.cmd;    assign ifb.exe_cmd = drv.cmd;
  assign ifa.mem_write = drv.mw;   assign ifb.mem_write = drv.mw;
  assign ifa.mem_read = drv.mr;    assign ifb.mem_read = drv.mr;
  assign ifa.br_type = drv.br;     assign ifb.br_type = drv.br;
  assign ifa.writeback_en = drv.wb; assign ifb.writeback_en = drv.wb;
  assign ifa.alu_inp1 = drv.a1;    assign ifb.alu_inp1 = drv.a1;
  assign ifa.alu_inp2 = drv.a2;    assign ifb.alu_inp2 = drv.a2;
  assign ifa.reg2 = drv.r2;        assign ifb.reg2 = drv.r2;
  assign ifa.idexe_dest = drv.dest; assign ifb.idexe_dest = drv.dest;
  assign ifa.PC = drv.pc;          assign ifb.PC = drv.pc;
`ifdef IDEXE_FWD_EN
  assign ifa.src1 = drv.s1;        assign ifb.src1 = drv.s1;
  assign ifa.src2 = drv.s2;        assign ifb.src2 = drv.s2;
`endif

  function automatic pay_t act_pay();
    pay_t p;
    p = '0;
    p.cmd = ifa.exe_cmd_exe; p.mw = ifa.mem_write_exe; p.mr = ifa.mem_read_exe;
    p.br = ifa.br_type_exe;  p.wb = ifa.writeback_en_exe;
    p.a1 = ifa.alu_inp1_exe; p.a2 = ifa.alu_inp2_exe; p.r2 = ifa.reg2_exe;
    p.dest = ifa.idexe_dest_exe; p.pc = ifa.PC_exe;
`ifdef IDEXE_FWD_EN
    p.s1 = ifa.src1_exe; p.s2 = ifa.src2_exe;
`endif
    return p;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    p = '0;
    p.cmd = 4'($urandom); p.mw = 1'($urandom); p.mr = 1'($urandom);
    p.br = 2'($urandom);  p.wb = 1'($urandom);
    p.a1 = $urandom; p.a2 = $urandom; p.r2 = $urandom;
    p.dest = 5'($urandom); p.pc = $urandom;
`ifdef IDEXE_FWD_EN
    p.s1 = 5'($urandom); p.s2 = 5'($urandom);
`endif
    return p;
  endfunction

  function automatic pay_t mk(input logic [3:0] cmd, input logic mw, input logic mr,
                              input logic [1:0] br, input logic wb, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [4:0] dest,
                              input logic [4:0] s1, input logic [4:0] s2);
    pay_t p;
    p = '0;
    p.cmd = cmd; p.mw = mw; p.mr = mr; p.br = br; p.wb = wb;
    p.a1 = a1; p.a2 = a2; p.r2 = a1 ^ a2; p.dest = dest; p.pc = a1 + 32'd4;
`ifdef IDEXE_FWD_EN
    p.s1 = s1; p.s2 = s2;
`else
    if (s1 != s2) p.r2 = p.r2 + 32'd0;
`endif
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one edge worth of inputs and push what the outputs must be after that edge
  task automatic step(input logic r, input logic s, input logic f, input logic h, input pay_t p);
    @(negedge clk);
    rst = r; st = s; fl = f; ho = h; drv = p;
    if (r) begin
      mdl = '0;
    end else if (f || (!h && s)) begin
      mdl.pay = '0;
      mdl.v   = 1'b0;
      if (mdl.c != 16'hFFFF) mdl.c = mdl.c + 16'd1;
      if (mdl.c4 != 4'hF) mdl.c4 = mdl.c4 + 4'd1;
    end else if (!h) begin
      mdl.pay = p;
      mdl.v   = 1'b1;
    end
    sb_q.push_back(mdl);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: every edge after which a result is owed, compare DUT against scoreboard head
  initial begin
    exp_t e;
    pay_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = act_pay();
        checks++;
        if (a !== e.pay) begin
          errors++;
          $display("FAIL payload: got %h expected %h", a, e.pay);
        end
        chk("valid_exe", 64'(ifa.valid_exe), 64'(e.v));
        chk("bubble_cnt", 64'(ifa.bubble_cnt), 64'(e.c));
        chk("bubble_cnt4", 64'(ifb.bubble_cnt), 64'(e.c4));
      end
    end
  end

  initial begin
    pay_t pa, pb;
    rst = 1'b1; st = 1'b0; fl = 1'b0; ho = 1'b0; drv = '0; mdl = '0;
    // reset with everything random
    repeat (2) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), rnd_pay());
    settle();
    chk("reset valid", 64'(ifa.valid_exe), 64'd0);
    chk("reset cmd", 64'(ifa.exe_cmd_exe), 64'd0);
    // plain load
    pa = mk(4'h3, 1'b0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h20, 5'd7, 5'd3, 5'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, pa);
    settle();
    chk("load cmd", 64'(ifa.exe_cmd_exe), 64'h3);
    chk("load a1", 64'(ifa.alu_inp1_exe), 64'h10);
    chk("load a2", 64'(ifa.alu_inp2_exe), 64'h20);
    chk("load dest", 64'(ifa.idexe_dest_exe), 64'd7);
    chk("load wb", 64'(ifa.writeback_en_exe), 64'd1);
`ifdef IDEXE_FWD_EN
    chk("load src1", 64'(ifa.src1_exe), 64'd3);
    chk("load src2", 64'(ifa.src2_exe), 64'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0, rnd_pay());
    settle();
    chk("flush src1", 64'(ifa.src1_exe), 64'd0);
    chk("flush src2", 64'(ifa.src2_exe), 64'd0);
`endif
    // stall with a store in ID: bubble, no store
    pb = mk(4'h5, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1, 32'h2, 5'd9, 5'd1, 5'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, pb);
    settle();
    chk("stall mw", 64'(ifa.mem_write_exe), 64'd0);
    chk("stall dest", 64'(ifa.idexe_dest_exe), 64'd0);
    // load a branch/load instr, then hold three cycles with changing inputs
    pb = mk(4'hA, 1'b0, 1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 5'd5, 5'd6);
    step(1'b0, 1'b0, 1'b0, 1'b0, pb);
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_pay());
    step(1'b0, 1'b1, 1'b0, 1'b1, rnd_pay());
    step(1'b0, 1'b0, 1'b0, 1'b1, rnd_pay());
    settle();
    chk("hold a1", 64'(ifa.alu_inp1_exe), 64'hDEAD_BEEF);
    chk("hold br", 64'(ifa.br_type_exe), 64'd2);
    // flush beats hold
    step(1'b0, 1'b0, 1'b1, 1'b1, pb);
    settle();
    chk("flush+hold mr", 64'(ifa.mem_read_exe), 64'd0);
    // flush with stall, then a long stall run saturates the narrow counter
    step(1'b0, 1'b1, 1'b1, 1'b0, pb);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_pay());
    settle();
    chk("cnt4 sat", 64'(ifb.bubble_cnt), 64'hF);
    // reset during hold wins; next edge stalls normally
    step(1'b0, 1'b0, 1'b0, 1'b0, pa);
    step(1'b1, 1'b1, 1'b0, 1'b1, rnd_pay());
    step(1'b0, 1'b1, 1'b0, 1'b0, pa);
    settle();
    chk("post-reset cnt", 64'(ifa.bubble_cnt), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, pb);
    step(1'b0, 1'b0, 1'b0, 1'b0, pa);
    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
